fft_bank_addr_gen: RTL and testbench



---
 rtl/fft_bank_addr_gen.sv | 204 ++++++++++++++++++++
 tb/tb_fft_bank_addr_gen.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bank_addr_gen.sv
// rtl/fft_bank_addr_gen.sv - multi-bank SRAM load/compute address and enable generator for the FFT core
module fft_bank_addr_gen #(
  parameter int AddrWidth = 7,
  parameter int NumBanks  = 4,
  parameter int NumStages = 4,
  parameter int WbLatency = 6
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 start_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  output logic [NumBanks-1:0]                  wen_o,
  output logic [NumBanks-1:0][AddrWidth-1:0]   waddr_o,
  output logic [NumBanks-1:0]                  ren_o,
  output logic [NumBanks-1:0][AddrWidth-1:0]   raddr_o,
  output logic [$clog2(NumStages+1)-1:0]       stage_o,
  output logic                                 busy_o,
  output logic                                 start_fft_o,
  output logic                                 done_o
);

  localparam int BankBits = $clog2(NumBanks);
  localparam int CntW     = AddrWidth + BankBits;
  localparam int StageW   = $clog2(NumStages + 1);

  localparam logic [CntW-1:0]      LdLast    = {CntW{1'b1}};
  localparam logic [AddrWidth-1:0] RdLast    = {AddrWidth{1'b1}};
  localparam logic [StageW-1:0]    LastStage = StageW'(NumStages);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // stage_q holds the external encoding: 0 while loading, s+1 during compute stage s
  logic [2:0]                              state_q, state_d;
  logic [CntW-1:0]                         ld_cnt_q, ld_cnt_d;
  logic [AddrWidth-1:0]                    rd_cnt_q, rd_cnt_d;
  logic [StageW-1:0]                       stage_q, stage_d;
  logic [WbLatency-1:0]                    dl_vld_q, dl_vld_d;
  logic [WbLatency-1:0][AddrWidth-1:0]     dl_addr_q, dl_addr_d;

  logic                                    in_ready_q, in_ready_d;
  logic [NumBanks-1:0]                     wen_q, wen_d;
  logic [NumBanks-1:0][AddrWidth-1:0]      waddr_q, waddr_d;
  logic [NumBanks-1:0]                     ren_q, ren_d;
  logic [NumBanks-1:0][AddrWidth-1:0]      raddr_q, raddr_d;
  logic [StageW-1:0]                       stage_out_q, stage_out_d;
  logic                                    busy_q, busy_d;
  logic                                    start_fft_q, start_fft_d;
  logic                                    done_q, done_d;

  logic                                    accept;
  logic                                    issue;
  logic                                    wb_vld;
  logic [AddrWidth-1:0]                    wb_addr;
  logic                                    last_wb;

  // A restart in the same cycle suppresses both a load acceptance and a read issue
  assign accept  = (state_q == ST_LOAD) && in_valid_i && !start_i;
  assign issue   = (state_q == ST_RD) && !start_i;
  assign wb_vld  = dl_vld_q[WbLatency-1];
  assign wb_addr = dl_addr_q[WbLatency-1];
  assign last_wb = (state_q == ST_DRAIN) && wb_vld && (wb_addr == RdLast);

  // Next-state, counters and write-back delay line; start_i overrides everything
  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    stage_d     = stage_q;
    dl_vld_d    = '0;
    dl_addr_d   = '0;
    dl_vld_d[0]  = issue;
    dl_addr_d[0] = rd_cnt_q;
    for (int i = 1; i < WbLatency; i++) begin
      dl_vld_d[i]  = dl_vld_q[i-1];
      dl_addr_d[i] = dl_addr_q[i-1];
    end
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (accept) begin
          if (ld_cnt_q == LdLast) begin
            state_d  = ST_RD;
            ld_cnt_d = '0;
            rd_cnt_d = '0;
            stage_d  = StageW'(1);
          end else begin
            ld_cnt_d = ld_cnt_q + CntW'(1);
          end
        end
      end
      ST_RD: begin
        if (rd_cnt_q == RdLast) begin
          state_d  = ST_DRAIN;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + AddrWidth'(1);
        end
      end
      ST_DRAIN: begin
        if (last_wb) begin
          if (stage_q == LastStage) begin
            state_d = ST_DONE;
            stage_d = '0;
          end else begin
            state_d = ST_RD;
            stage_d = stage_q + StageW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (start_i) begin
      state_d  = ST_LOAD;
      ld_cnt_d = '0;
      rd_cnt_d = '0;
      stage_d  = '0;
      dl_vld_d = '0;
    end
  end

  // Registered outputs: load writes, write-backs and reads for the next cycle
  always_comb begin
    in_ready_d  = (state_d == ST_LOAD);
    wen_d       = '0;
    waddr_d     = '0;
    ren_d       = '0;
    raddr_d     = '0;
    if (accept) begin
      wen_d[ld_cnt_q[BankBits-1:0]] = 1'b1;
      waddr_d = {NumBanks{ld_cnt_q[CntW-1:BankBits]}};
    end else if (wb_vld && !start_i) begin
      wen_d   = '1;
      waddr_d = {NumBanks{wb_addr}};
    end
    if (issue) begin
      ren_d   = '1;
      raddr_d = {NumBanks{rd_cnt_q}};
    end
    stage_out_d = start_i ? '0 : stage_q;
    busy_d      = start_i || (state_q != ST_IDLE);
    start_fft_d = issue && (stage_q == StageW'(1)) && (rd_cnt_q == '0);
    done_d      = (state_q == ST_DONE) && !start_i;
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ld_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      stage_q     <= '0;
      dl_vld_q    <= '0;
      dl_addr_q   <= '0;
      in_ready_q  <= 1'b0;
      wen_q       <= '0;
      waddr_q     <= '0;
      ren_q       <= '0;
      raddr_q     <= '0;
      stage_out_q <= '0;
      busy_q      <= 1'b0;
      start_fft_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      stage_q     <= stage_d;
      dl_vld_q    <= dl_vld_d;
      dl_addr_q   <= dl_addr_d;
      in_ready_q  <= in_ready_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      ren_q       <= ren_d;
      raddr_q     <= raddr_d;
      stage_out_q <= stage_out_d;
      busy_q      <= busy_d;
      start_fft_q <= start_fft_d;
      done_q      <= done_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign wen_o       = wen_q;
  assign waddr_o     = waddr_q;
  assign ren_o       = ren_q;
  assign raddr_o     = raddr_q;
  assign stage_o     = stage_out_q;
  assign busy_o      = busy_q;
  assign start_fft_o = start_fft_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_fft_bank_addr_gen.sv
// tb/tb_fft_bank_addr_gen.sv - directed self-checking bench for fft_bank_addr_gen
module tb_fft_bank_addr_gen;

  logic             clk_i;
  logic             rst_ni;
  logic             start_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [3:0]       wen_o;
  logic [3:0][6:0]  waddr_o;
  logic [3:0]       ren_o;
  logic [3:0][6:0]  raddr_o;
  logic [2:0]       stage_o;
  logic             busy_o;
  logic             start_fft_o;
  logic             done_o;
  logic [70:0]      all_out;

  int checks;
  int errors;

  assign all_out = {in_ready_o, wen_o, waddr_o, ren_o, raddr_o, stage_o, busy_o, start_fft_o, done_o};

  fft_bank_addr_gen #(
    .AddrWidth(7),
    .NumBanks (4),
    .NumStages(4),
    .WbLatency(6)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .wen_o      (wen_o),
    .waddr_o    (waddr_o),
    .ren_o      (ren_o),
    .raddr_o    (raddr_o),
    .stage_o    (stage_o),
    .busy_o     (busy_o),
    .start_fft_o(start_fft_o),
    .done_o     (done_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni     = 1'b1;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_hold outputs=%h required=0", all_out);
    end
    rst_ni = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (all_out !== '0) begin
        errors++;
        $display("FAIL idle cycle=%0d outputs=%h required=0", i, all_out);
      end
    end
  endtask

  task automatic test_load();
    int bank;
    logic [3:0] ew;
    start_i = 1'b1;
    step();
    start_i    = 1'b0;
    in_valid_i = 1'b1;
    checks++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b1 || wen_o !== 4'h0) begin
      errors++;
      $display("FAIL load_entry ready=%b busy=%b wen=%b required 1 1 0000", in_ready_o, busy_o, wen_o);
    end
    for (int k = 0; k < 512; k++) begin
      step();
      bank = k % 4;
      ew   = 4'b0001 << bank;
      checks++;
      if (wen_o !== ew || waddr_o[bank] !== 7'(k / 4)) begin
        errors++;
        $display("FAIL load_wr k=%0d wen=%b waddr=%0d required wen=%b waddr=%0d",
                 k, wen_o, waddr_o[bank], ew, k / 4);
      end
      checks++;
      if (in_ready_o !== (k < 511)) begin
        errors++;
        $display("FAIL load_ready k=%0d ready=%b required=%b", k, in_ready_o, (k < 511));
      end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic test_transform();
    int loc, s;
    logic [3:0] ew, er;
    logic [6:0] aw, ar;
    logic [2:0] es;
    logic eb, ed, esf;
    for (int t = 0; t < 538; t++) begin
      step();
      if (t < 536) begin
        s   = t / 134;
        loc = t % 134;
        er  = (loc < 128) ? 4'hF : 4'h0;
        ar  = 7'(loc);
        ew  = (loc >= 6) ? 4'hF : 4'h0;
        aw  = 7'(loc - 6);
        es  = 3'(s + 1);
        eb  = 1'b1;
        ed  = 1'b0;
        esf = (t == 0);
      end else begin
        er  = 4'h0;
        ar  = '0;
        ew  = 4'h0;
        aw  = '0;
        es  = 3'd0;
        eb  = (t == 536);
        ed  = (t == 536);
        esf = 1'b0;
      end
      checks++;
      if ({wen_o, ren_o} !== {ew, er}) begin
        errors++;
        $display("FAIL xfer_en t=%0d wen=%b ren=%b required wen=%b ren=%b", t, wen_o, ren_o, ew, er);
      end
      if (ew != 4'h0) begin
        checks++;
        if (waddr_o !== {4{aw}}) begin
          errors++;
          $display("FAIL xfer_waddr t=%0d waddr=%h required lanes=%0d", t, waddr_o, aw);
        end
      end
      if (er != 4'h0) begin
        checks++;
        if (raddr_o !== {4{ar}}) begin
          errors++;
          $display("FAIL xfer_raddr t=%0d raddr=%h required lanes=%0d", t, raddr_o, ar);
        end
      end
      checks++;
      if ({stage_o, busy_o, start_fft_o, done_o} !== {es, eb, esf, ed}) begin
        errors++;
        $display("FAIL xfer_ctl t=%0d stage=%0d busy=%b start_fft=%b done=%b required %0d %b %b %b",
                 t, stage_o, busy_o, start_fft_o, done_o, es, eb, esf, ed);
      end
    end
  endtask

  task automatic test_gapped_load();
    int k;
    int writes;
    int bank;
    bit prev_v;
    logic [3:0] ew;
    k      = 0;
    writes = 0;
    start_i = 1'b1;
    step();
    start_i    = 1'b0;
    prev_v     = 1'b1;
    in_valid_i = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      step();
      if (wen_o != 4'h0) writes++;
      if (prev_v) begin
        bank = k % 4;
        ew   = 4'b0001 << bank;
        checks++;
        if (wen_o !== ew || waddr_o[bank] !== 7'(k / 4)) begin
          errors++;
          $display("FAIL gap_wr k=%0d wen=%b waddr=%0d required wen=%b waddr=%0d",
                   k, wen_o, waddr_o[bank], ew, k / 4);
        end
        k++;
      end else begin
        checks++;
        if (wen_o !== 4'h0) begin
          errors++;
          $display("FAIL gap_hold i=%0d wen=%b required=0000", i, wen_o);
        end
      end
      checks++;
      if (in_ready_o !== (k < 512)) begin
        errors++;
        $display("FAIL gap_ready i=%0d ready=%b required=%b", i, in_ready_o, (k < 512));
      end
      prev_v     = (k < 512) && (i % 2 == 1);
      in_valid_i = prev_v;
    end
    checks++;
    if (writes != 512) begin
      errors++;
      $display("FAIL gap_count writes=%0d required=512", writes);
    end
    checks++;
    if (start_fft_o !== 1'b1 || ren_o !== 4'hF) begin
      errors++;
      $display("FAIL gap_start_fft start_fft=%b ren=%b required 1 1111", start_fft_o, ren_o);
    end
  endtask

  task automatic test_restart();
    for (int t = 1; t <= 398; t++) step();
    checks++;
    if (wen_o !== 4'hF || waddr_o[0] !== 7'd124 || ren_o !== 4'h0 || stage_o !== 3'd3) begin
      errors++;
      $display("FAIL restart_pre wen=%b waddr0=%0d ren=%b stage=%0d required 1111 124 0000 3",
               wen_o, waddr_o[0], ren_o, stage_o);
    end
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    checks++;
    if (wen_o !== 4'h0 || ren_o !== 4'h0 || in_ready_o !== 1'b1 || stage_o !== 3'd0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL restart_now wen=%b ren=%b ready=%b stage=%0d busy=%b required 0000 0000 1 0 1",
               wen_o, ren_o, in_ready_o, stage_o, busy_o);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (wen_o !== 4'h0 || ren_o !== 4'h0 || in_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL restart_flush i=%0d wen=%b ren=%b ready=%b required 0000 0000 1",
                 i, wen_o, ren_o, in_ready_o);
      end
    end
  endtask

  task automatic test_async_reset();
    bit found;
    found      = 1'b0;
    in_valid_i = 1'b1;
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      if (start_fft_o === 1'b1) found = 1'b1;
    end
    in_valid_i = 1'b0;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL arst_wait start_fft=0 required=1 within 600 cycles");
    end
    repeat (140) step();
    checks++;
    if (ren_o !== 4'hF || raddr_o[0] !== 7'd6 || stage_o !== 3'd2) begin
      errors++;
      $display("FAIL arst_pre ren=%b raddr0=%0d stage=%0d required 1111 6 2", ren_o, raddr_o[0], stage_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL arst_clear outputs=%h required=0", all_out);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (all_out !== '0) begin
        errors++;
        $display("FAIL arst_idle cycle=%0d outputs=%h required=0", i, all_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ew;
    start_i = 1'b1;
    step();
    start_i    = 1'b0;
    in_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      ew = 4'b0001 << k;
      checks++;
      if (wen_o !== ew || waddr_o[k] !== 7'd0) begin
        errors++;
        $display("FAIL b2b_wr k=%0d wen=%b waddr=%0d required wen=%b waddr=0", k, wen_o, waddr_o[k], ew);
      end
    end
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    checks++;
    if (wen_o !== 4'h0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drop wen=%b ready=%b required 0000 1", wen_o, in_ready_o);
    end
    step();
    checks++;
    if (wen_o !== 4'b0001 || waddr_o[0] !== 7'd0) begin
      errors++;
      $display("FAIL b2b_first wen=%b waddr0=%0d required 0001 0", wen_o, waddr_o[0]);
    end
    step();
    checks++;
    if (wen_o !== 4'b0010 || waddr_o[1] !== 7'd0) begin
      errors++;
      $display("FAIL b2b_second wen=%b waddr1=%0d required 0010 0", wen_o, waddr_o[1]);
    end
    in_valid_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load();
    test_transform();
    test_gapped_load();
    test_restart();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
